// File: rtl/hamm_deframer_param.sv
// Serial Hamming (SEC or SEC-DED) codeword deframer. It parses a length header,
// frames the payload words, and reports error counts, timeouts and aborts.
module hamm_deframer_param #(
   parameter int DATA_W      = 8,
   parameter int EXT_PAR     = 0,
   parameter int LEN_SHIFT   = 2,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_ds_valid,
   input  logic              i_ds_data,
   input  logic              i_sync_valid_pulse,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_sof,
   output logic              o_eof,
   output logic              o_uncorr,
   output logic [31:0]       o_frame_len,
   output logic              o_frame_done,
   output logic              o_abort,
   output logic              o_timeout,
   output logic [15:0]       o_corr_cnt,
   output logic [15:0]       o_uncorr_cnt,
   output logic              o_busy
);

   function automatic int calc_p(input int dw);
      int p;
      p = 0;
      for (int i = 8; i >= 1; i--)
         if ((1 << i) >= dw + i + 1) p = i;
      return p;
   endfunction

   // Hamming position of data bit j: the j-th position that is not a power of two.
   function automatic int data_pos(input int j);
      int cnt;
      int r;
      cnt = 0;
      r   = 0;
      for (int pos = 3; pos <= 64; pos++)
         if ((pos & (pos - 1)) != 0) begin
            if (cnt == j && r == 0) r = pos;
            cnt++;
         end
      return r;
   endfunction

   localparam int P      = calc_p(DATA_W);
   localparam int N      = DATA_W + P;
   localparam int CODE_W = N + EXT_PAR;
   localparam int CNT_W  = $clog2(CODE_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CODE_W - 1);
   localparam logic [P-1:0]     N_P      = P'(N);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HDR  = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   logic [1:0]        state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CODE_W-1:0] shreg;
   logic              word_done;
   logic [CODE_W-1:0] cw_q;
   logic              cw_vld;
   logic [P-1:0]      syn_c;
   logic [P-1:0]      syn_q;
   logic              par_q;
   logic [N-1:0]      cw2_q;
   logic              vld2;
   logic [N-1:0]      dec_fixed;
   logic [DATA_W-1:0] dec_data;
   logic              dec_corr;
   logic              dec_unc;
   logic [31:0]       hdr_val;
   logic [31:0]       hdr_words;
   logic [31:0]       remaining;
   logic              first_word;
   logic [31:0]       idle_cnt;
   logic              timeout_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         shreg     <= '0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;
         if (i_sync_valid_pulse || state == IDLE) begin
            bit_cnt <= '0;
         end else if (i_ds_valid) begin
            shreg[bit_cnt] <= i_ds_data;
            if (bit_cnt == LAST_BIT) begin
               bit_cnt   <= '0;
               word_done <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      syn_c = '0;
      for (int i = 0; i < N; i++)
         if (cw_q[i]) syn_c = syn_c ^ P'(i + 1);
   end

   // A sync pulse kills every word still travelling through the pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         cw_q   <= '0;
         cw_vld <= 1'b0;
         syn_q  <= '0;
         par_q  <= 1'b0;
         cw2_q  <= '0;
         vld2   <= 1'b0;
      end else begin
         cw_vld <= word_done && !i_sync_valid_pulse;
         if (word_done) cw_q <= shreg;
         vld2  <= cw_vld && !i_sync_valid_pulse;
         syn_q <= syn_c;
         par_q <= ^cw_q;
         cw2_q <= cw_q[N-1:0];
      end
   end

   always_comb begin
      dec_corr  = 1'b0;
      dec_unc   = 1'b0;
      dec_fixed = cw2_q;
      if (EXT_PAR != 0) begin
         if (par_q) begin
            if (syn_q <= N_P) dec_corr = 1'b1;
            else              dec_unc  = 1'b1;
         end else if (syn_q != '0) begin
            dec_unc = 1'b1;
         end
      end else if (syn_q != '0) begin
         if (syn_q <= N_P) dec_corr = 1'b1;
         else              dec_unc  = 1'b1;
      end
      for (int i = 0; i < N; i++)
         if (dec_corr && syn_q == P'(i + 1)) dec_fixed[i] = ~cw2_q[i];
   end

   for (genvar g = 0; g < DATA_W; g++) begin : g_extract
      assign dec_data[g] = dec_fixed[data_pos(g) - 1];
   end

   always_comb begin
      hdr_val               = '0;
      hdr_val[DATA_W-1:0]   = dec_data;
      hdr_words             = hdr_val << LEN_SHIFT;
   end

   always_ff @(posedge clk) begin
      if (rst || state == IDLE || i_ds_valid || i_sync_valid_pulse)
         idle_cnt <= '0;
      else if (idle_cnt != '1)
         idle_cnt <= idle_cnt + 32'd1;
   end

   assign timeout_hit = (TIMEOUT_CYC != 0) && (idle_cnt >= 32'(TIMEOUT_CYC));
   assign o_busy      = (state != IDLE);

   // Priority: resync, then timeout, then the decoded word leaving the pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         remaining    <= '0;
         first_word   <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_sof        <= 1'b0;
         o_eof        <= 1'b0;
         o_uncorr     <= 1'b0;
         o_frame_len  <= '0;
         o_frame_done <= 1'b0;
         o_abort      <= 1'b0;
         o_timeout    <= 1'b0;
         o_corr_cnt   <= '0;
         o_uncorr_cnt <= '0;
      end else begin
         o_valid      <= 1'b0;
         o_sof        <= 1'b0;
         o_eof        <= 1'b0;
         o_uncorr     <= 1'b0;
         o_frame_done <= 1'b0;
         o_abort      <= 1'b0;
         o_timeout    <= 1'b0;
         if (i_sync_valid_pulse) begin
            if (state != IDLE) o_abort <= 1'b1;
            state <= HDR;
         end else if (state != IDLE && timeout_hit) begin
            o_abort   <= 1'b1;
            o_timeout <= 1'b1;
            state     <= IDLE;
         end else if (state != IDLE && vld2) begin
            if (dec_corr && o_corr_cnt != 16'hFFFF)  o_corr_cnt   <= o_corr_cnt + 16'd1;
            if (dec_unc && o_uncorr_cnt != 16'hFFFF) o_uncorr_cnt <= o_uncorr_cnt + 16'd1;
            if (state == HDR) begin
               if (dec_unc) begin
                  o_abort <= 1'b1;
                  state   <= IDLE;
               end else begin
                  o_frame_len <= hdr_val;
                  remaining   <= hdr_words;
                  first_word  <= 1'b1;
                  if (hdr_words == '0) begin
                     o_frame_done <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     state <= DATA;
                  end
               end
            end else begin
               o_valid    <= 1'b1;
               o_data     <= dec_data;
               o_sof      <= first_word;
               o_eof      <= (remaining == 32'd1);
               o_uncorr   <= dec_unc;
               first_word <= 1'b0;
               remaining  <= remaining - 32'd1;
               if (remaining == 32'd1) begin
                  o_frame_done <= 1'b1;
                  state        <= IDLE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_hamm_deframer_param.sv
// Bench for hamm_deframer_param: a SEC instance (DATA_W=8) and a SEC-DED
// instance (DATA_W=16), each scored against a queue of expected payload words.
module tb_hamm_deframer_param;

   typedef struct {
      logic [31:0] data;
      logic        sof;
      logic        eof;
      logic        unc;
   } exp_t;

   localparam int A_CW = 12;
   localparam int B_CW = 22;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, a_bit, a_sync;
   logic [7:0]  a_odata;
   logic        a_ovalid, a_sof, a_eof, a_unc, a_done, a_abort, a_timeout, a_busy;
   logic [31:0] a_flen;
   logic [15:0] a_corr, a_uncnt;
   logic        b_valid, b_bit, b_sync;
   logic [15:0] b_odata;
   logic        b_ovalid, b_sof, b_eof, b_unc, b_done, b_abort, b_timeout, b_busy;
   logic [31:0] b_flen;
   logic [15:0] b_corr, b_uncnt;

   exp_t a_q[$];
   exp_t b_q[$];
   exp_t a_e, b_e;
   int   n_checks = 0;
   int   n_pass = 0;
   int   a_done_n = 0, a_abort_n = 0, a_to_n = 0;
   int   b_done_n = 0, b_abort_n = 0;

   hamm_deframer_param #(.DATA_W(8), .EXT_PAR(0), .LEN_SHIFT(2), .TIMEOUT_CYC(100)) dut_a (
      .clk(clk), .rst(rst), .i_ds_valid(a_valid), .i_ds_data(a_bit),
      .i_sync_valid_pulse(a_sync), .o_data(a_odata), .o_valid(a_ovalid), .o_sof(a_sof),
      .o_eof(a_eof), .o_uncorr(a_unc), .o_frame_len(a_flen), .o_frame_done(a_done),
      .o_abort(a_abort), .o_timeout(a_timeout), .o_corr_cnt(a_corr),
      .o_uncorr_cnt(a_uncnt), .o_busy(a_busy));

   hamm_deframer_param #(.DATA_W(16), .EXT_PAR(1), .LEN_SHIFT(2), .TIMEOUT_CYC(100)) dut_b (
      .clk(clk), .rst(rst), .i_ds_valid(b_valid), .i_ds_data(b_bit),
      .i_sync_valid_pulse(b_sync), .o_data(b_odata), .o_valid(b_ovalid), .o_sof(b_sof),
      .o_eof(b_eof), .o_uncorr(b_unc), .o_frame_len(b_flen), .o_frame_done(b_done),
      .o_abort(b_abort), .o_timeout(b_timeout), .o_corr_cnt(b_corr),
      .o_uncorr_cnt(b_uncnt), .o_busy(b_busy));

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic int p_of(input int dw);
      int p;
      p = 1;
      while ((1 << p) < dw + p + 1) p++;
      return p;
   endfunction

   function automatic logic [63:0] encode(input int dw, input int ext, input logic [31:0] d);
      logic [63:0] cw;
      logic        par;
      int          n;
      int          k;
      cw = '0;
      n  = dw + p_of(dw);
      k  = 0;
      for (int pos = 1; pos <= n; pos++)
         if ((pos & (pos - 1)) != 0) begin
            cw[pos-1] = d[k];
            k++;
         end
      for (int b = 0; (1 << b) <= n; b++) begin
         par = 1'b0;
         for (int pos = 1; pos <= n; pos++)
            if (((pos >> b) & 1) != 0) par = par ^ cw[pos-1];
         cw[(1 << b) - 1] = par;
      end
      if (ext != 0) cw[n] = ^cw;
      return cw;
   endfunction

   function automatic logic [31:0] extract(input int dw, input logic [63:0] cw);
      logic [31:0] d;
      int          n;
      int          k;
      d = '0;
      n = dw + p_of(dw);
      k = 0;
      for (int pos = 1; pos <= n; pos++)
         if ((pos & (pos - 1)) != 0) begin
            d[k] = cw[pos-1];
            k++;
         end
      return d;
   endfunction

   function automatic exp_t mk(input logic [31:0] d, input logic s, input logic e, input logic u);
      exp_t r;
      r.data = d;
      r.sof  = s;
      r.eof  = e;
      r.unc  = u;
      return r;
   endfunction

   task automatic drive_bit(input int inst, input logic b);
      @(negedge clk);
      if (inst == 0) begin a_valid = 1'b1; a_bit = b; end
      else           begin b_valid = 1'b1; b_bit = b; end
   endtask

   task automatic drive_idle(input int inst, input int n);
      repeat (n) begin
         @(negedge clk);
         if (inst == 0) a_valid = 1'b0;
         else           b_valid = 1'b0;
      end
   endtask

   task automatic pulse_sync(input int inst);
      @(negedge clk);
      if (inst == 0) begin a_valid = 1'b0; a_sync = 1'b1; end
      else           begin b_valid = 1'b0; b_sync = 1'b1; end
      @(negedge clk);
      a_sync = 1'b0;
      b_sync = 1'b0;
   endtask

   // Expected word is queued as the codeword is driven; the monitors pop it on o_valid.
   task automatic apply_stimulus(input int inst, input logic [63:0] cw, input int w,
                                 input bit expect_out, input exp_t e);
      if (expect_out) begin
         if (inst == 0) a_q.push_back(e);
         else           b_q.push_back(e);
      end
      for (int i = 0; i < w; i++) drive_bit(inst, cw[i]);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (a_done)  a_done_n++;
         if (a_abort) a_abort_n++;
         if (a_timeout) a_to_n++;
         if (a_ovalid) begin
            check_output("a_word_expected", 32'(a_q.size() != 0), 1);
            if (a_q.size() != 0) begin
               a_e = a_q.pop_front();
               check_output("a_data", a_odata, a_e.data);
               check_output("a_sof", a_sof, a_e.sof);
               check_output("a_eof", a_eof, a_e.eof);
               check_output("a_uncorr", a_unc, a_e.unc);
               check_output("a_done_with_eof", a_done, a_e.eof);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (b_done)  b_done_n++;
         if (b_abort) b_abort_n++;
         if (b_ovalid) begin
            check_output("b_word_expected", 32'(b_q.size() != 0), 1);
            if (b_q.size() != 0) begin
               b_e = b_q.pop_front();
               check_output("b_data", b_odata, b_e.data);
               check_output("b_sof", b_sof, b_e.sof);
               check_output("b_eof", b_eof, b_e.eof);
               check_output("b_uncorr", b_unc, b_e.unc);
               check_output("b_done_with_eof", b_done, b_e.eof);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] cw;
      logic [31:0] d;
      int          idx, i1, i2, cyc, got_it, abort_at_to;

      rst = 1'b1;
      a_valid = 1'b0; a_bit = 1'b0; a_sync = 1'b0;
      b_valid = 1'b0; b_bit = 1'b0; b_sync = 1'b0;
      repeat (3) @(negedge clk);
      check_output("a_rst_valid", a_ovalid, 0);
      check_output("a_rst_busy", a_busy, 0);
      check_output("a_rst_flen", a_flen, 0);
      check_output("a_rst_corr", a_corr, 0);
      check_output("b_rst_busy", b_busy, 0);
      check_output("b_rst_uncnt", b_uncnt, 0);
      rst = 1'b0;
      drive_idle(0, 2);

      $display("[TB] clean frame, header 0x019 and 8 x 0xA27");
      pulse_sync(0);
      apply_stimulus(0, 64'h019, A_CW, 0, mk(0, 0, 0, 0));
      for (int i = 0; i < 8; i++)
         apply_stimulus(0, 64'hA27, A_CW, 1, mk(32'hA5, i == 0, i == 7, 0));
      drive_idle(0, 10);
      check_output("t1_q_empty", 32'(a_q.size()), 0);
      check_output("t1_flen", a_flen, 2);
      check_output("t1_corr", a_corr, 0);
      check_output("t1_uncnt", a_uncnt, 0);
      check_output("t1_done_n", a_done_n, 1);
      check_output("t1_busy", a_busy, 0);

      $display("[TB] single-bit flips in header and payload");
      pulse_sync(0);
      apply_stimulus(0, 64'h009, A_CW, 0, mk(0, 0, 0, 0));
      for (int i = 0; i < 8; i++)
         apply_stimulus(0, (i == 2) ? 64'hA07 : 64'hA27, A_CW, 1, mk(32'hA5, i == 0, i == 7, 0));
      drive_idle(0, 10);
      check_output("t2_q_empty", 32'(a_q.size()), 0);
      check_output("t2_corr", a_corr, 2);
      check_output("t2_uncnt", a_uncnt, 0);
      check_output("t2_done_n", a_done_n, 2);

      $display("[TB] zero-length header");
      pulse_sync(0);
      apply_stimulus(0, 64'h000, A_CW, 0, mk(0, 0, 0, 0));
      drive_idle(0, 1);
      cyc = 0; got_it = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (!got_it && a_done) begin got_it = 1; cyc = i; end
      end
      check_output("t3_done_latency", cyc, 3);
      check_output("t3_busy", a_busy, 0);
      check_output("t3_flen", a_flen, 0);
      check_output("t3_done_n", a_done_n, 3);

      $display("[TB] stream stops after 3 payload words");
      pulse_sync(0);
      apply_stimulus(0, 64'h019, A_CW, 0, mk(0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         apply_stimulus(0, 64'hA27, A_CW, 1, mk(32'hA5, i == 0, 0, 0));
      drive_idle(0, 1);
      cyc = 0; got_it = 0; abort_at_to = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (!got_it && a_timeout) begin got_it = 1; cyc = i; abort_at_to = int'(a_abort); end
      end
      check_output("t4_timeout_window", 32'(cyc >= 100 && cyc <= 102), 1);
      check_output("t4_abort_with_timeout", abort_at_to, 1);
      check_output("t4_busy", a_busy, 0);
      check_output("t4_to_n", a_to_n, 1);
      check_output("t4_abort_n", a_abort_n, 1);
      check_output("t4_q_empty", 32'(a_q.size()), 0);

      $display("[TB] resync mid-payload, then frame with L=1");
      pulse_sync(0);
      apply_stimulus(0, 64'h019, A_CW, 0, mk(0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         apply_stimulus(0, 64'hA27, A_CW, 1, mk(32'hA5, i == 0, 0, 0));
      cw = 64'hA27;
      for (int i = 0; i < 5; i++) drive_bit(0, cw[i]);
      pulse_sync(0);
      apply_stimulus(0, encode(8, 0, 32'd1), A_CW, 0, mk(0, 0, 0, 0));
      for (int i = 0; i < 4; i++) begin
         d = 32'($urandom_range(0, 255));
         apply_stimulus(0, encode(8, 0, d), A_CW, 1, mk(d, i == 0, i == 3, 0));
      end
      drive_idle(0, 10);
      check_output("t5_abort_n", a_abort_n, 2);
      check_output("t5_to_n", a_to_n, 1);
      check_output("t5_done_n", a_done_n, 4);
      check_output("t5_flen", a_flen, 1);
      check_output("t5_q_empty", 32'(a_q.size()), 0);

      $display("[TB] SEC-DED DATA_W=16 frame with single and double errors");
      pulse_sync(1);
      cw = encode(16, 1, 32'd2);
      idx = $urandom_range(0, B_CW - 1);
      cw[idx] = ~cw[idx];
      apply_stimulus(1, cw, B_CW, 0, mk(0, 0, 0, 0));
      for (int i = 0; i < 8; i++) begin
         d  = 32'($urandom_range(0, 65535));
         cw = encode(16, 1, d);
         if (i == 1) begin
            i1 = $urandom_range(0, 20);
            i2 = (i1 + 1 + $urandom_range(0, 19)) % 21;
            cw[i1] = ~cw[i1];
            cw[i2] = ~cw[i2];
            apply_stimulus(1, cw, B_CW, 1, mk(extract(16, cw), 0, 0, 1));
         end else begin
            idx = $urandom_range(0, B_CW - 1);
            cw[idx] = ~cw[idx];
            apply_stimulus(1, cw, B_CW, 1, mk(d, i == 0, i == 7, 0));
         end
      end
      drive_idle(1, 10);
      check_output("t6_q_empty", 32'(b_q.size()), 0);
      check_output("t6_corr", b_corr, 8);
      check_output("t6_uncnt", b_uncnt, 1);
      check_output("t6_flen", b_flen, 2);
      check_output("t6_done_n", b_done_n, 1);

      $display("[TB] SEC-DED header with two errors");
      pulse_sync(1);
      cw = encode(16, 1, 32'd5);
      i1 = $urandom_range(0, 20);
      i2 = (i1 + 1 + $urandom_range(0, 19)) % 21;
      cw[i1] = ~cw[i1];
      cw[i2] = ~cw[i2];
      apply_stimulus(1, cw, B_CW, 0, mk(0, 0, 0, 0));
      drive_idle(1, 8);
      check_output("t7_abort_n", b_abort_n, 1);
      check_output("t7_flen_held", b_flen, 2);
      check_output("t7_uncnt", b_uncnt, 2);
      check_output("t7_busy", b_busy, 0);
      check_output("t7_done_n", b_done_n, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
